// File: rtl/matmul_pkg.sv
// Shared constants and state encoding for the 3x3 matrix multiplier.
// Imported by the sequencer top.
package matmul_pkg;

    localparam int N             = 3;
    localparam int DW            = 8;
    localparam int RW            = 18;
    localparam int ELEMS         = 9;
    localparam int BYTES_PER_RES = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_OUTPUT,
        S_FINISH
    } state_t;

    // Row-major flat index r*3 + c for the 3x3 arrays.
    function automatic logic [3:0] rc_idx(
        input logic [1:0] r,
        input logic [1:0] c
    );
        return {1'b0, r, 1'b0} + {2'b00, r} + {2'b00, c};
    endfunction

endpackage

// File: rtl/matmul_sequencer_mac_unit.sv
// Shared multiply-accumulate unit: DWxDW product into an RW-bit accumulator.
// acc_next exposes the sum being registered so a finished dot product can be stored the same cycle.
module mac_unit #(
    parameter int DW = 8,
    parameter int RW = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    input  logic          clear_load,
    input  logic          acc_en,
    output logic [RW-1:0] acc,
    output logic [RW-1:0] acc_next
);

    logic [2*DW-1:0] prod;
    logic [RW-1:0]   acc_q;

    assign prod     = op_a * op_b;
    assign acc_next = clear_load ? RW'(prod) : acc_q + RW'(prod);
    assign acc      = acc_q;

    // Accumulator: first term of a dot product replaces, later terms add.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (acc_en) begin
            acc_q <= acc_next;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Job controller for the 3x3 multiplier: load, 27-cycle MAC sweep, byte-serial output.
// Results leave as 24-bit little-endian words over a valid/ready handshake.
module matmul_sequencer #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int RW = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          load_en,
    input  logic          load_done,
    input  logic [DW-1:0] a_in [0:8],
    input  logic [DW-1:0] b_in [0:8],
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] LAST_IDX  = 2'(N - 1);
    localparam logic [3:0] LAST_ELEM = 4'(matmul_pkg::ELEMS - 1);
    localparam logic [1:0] LAST_BYTE = 2'(matmul_pkg::BYTES_PER_RES - 1);

    matmul_pkg::state_t state_q, state_d;

    logic [1:0]    i_q, i_d;
    logic [1:0]    j_q, j_d;
    logic [1:0]    k_q, k_d;
    logic [3:0]    e_q, e_d;
    logic [1:0]    b_q, b_d;
    logic [RW-1:0] c_q [0:8];

    logic [3:0]    a_idx;
    logic [3:0]    b_idx;
    logic [3:0]    c_idx;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          computing;
    logic          c_wr;
    logic          fire;
    logic [RW-1:0] acc;
    logic [RW-1:0] acc_next;
    logic [23:0]   res_w;
    logic [7:0]    byte_w;

    assign a_idx     = matmul_pkg::rc_idx(i_q, k_q);
    assign b_idx     = matmul_pkg::rc_idx(k_q, j_q);
    assign c_idx     = matmul_pkg::rc_idx(i_q, j_q);
    assign op_a      = a_in[a_idx];
    assign op_b      = b_in[b_idx];
    assign computing = (state_q == matmul_pkg::S_COMPUTE);
    assign c_wr      = computing && (k_q == LAST_IDX);

    mac_unit #(
        .DW(DW),
        .RW(RW)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .op_a      (op_a),
        .op_b      (op_b),
        .clear_load(k_q == 2'd0),
        .acc_en    (computing),
        .acc       (acc),
        .acc_next  (acc_next)
    );

    assign load_en   = (state_q == matmul_pkg::S_LOAD);
    assign out_valid = (state_q == matmul_pkg::S_OUTPUT);
    assign done      = (state_q == matmul_pkg::S_FINISH);
    assign busy      = load_en || computing || out_valid;
    assign fire      = out_valid && out_ready;

    assign res_w = 24'(c_q[e_q]);

    // Pick byte b of the current result, least significant first.
    always_comb begin
        byte_w = res_w[7:0];
        unique case (b_q)
            2'd1:    byte_w = res_w[15:8];
            2'd2:    byte_w = res_w[23:16];
            default: byte_w = res_w[7:0];
        endcase
    end

    assign out_data = out_valid ? byte_w : 8'h00;

    // State, loop counters and output cursor registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= matmul_pkg::S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            e_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            e_q     <= e_d;
            b_q     <= b_d;
        end
    end

    // Result file: the completed dot product lands on the k=last cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < 9; n++) begin
                c_q[n] <= '0;
            end
        end else if (c_wr) begin
            c_q[c_idx] <= acc_next;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        e_d     = e_q;
        b_d     = b_q;
        unique case (state_q)
            matmul_pkg::S_IDLE: begin
                if (start) begin
                    state_d = matmul_pkg::S_LOAD;
                end
            end
            matmul_pkg::S_LOAD: begin
                i_d = '0;
                j_d = '0;
                k_d = '0;
                if (load_done) begin
                    state_d = matmul_pkg::S_COMPUTE;
                end
            end
            matmul_pkg::S_COMPUTE: begin
                k_d = k_q + 2'd1;
                if (k_q == LAST_IDX) begin
                    k_d = '0;
                    j_d = j_q + 2'd1;
                    if (j_q == LAST_IDX) begin
                        j_d = '0;
                        i_d = i_q + 2'd1;
                        if (i_q == LAST_IDX) begin
                            i_d     = '0;
                            e_d     = '0;
                            b_d     = '0;
                            state_d = matmul_pkg::S_OUTPUT;
                        end
                    end
                end
            end
            matmul_pkg::S_OUTPUT: begin
                if (fire) begin
                    b_d = b_q + 2'd1;
                    if (b_q == LAST_BYTE) begin
                        b_d = '0;
                        e_d = e_q + 4'd1;
                        if (e_q == LAST_ELEM) begin
                            e_d     = '0;
                            state_d = matmul_pkg::S_FINISH;
                        end
                    end
                end
            end
            matmul_pkg::S_FINISH: begin
                state_d = matmul_pkg::S_FINISH;
            end
            default: begin
                state_d = matmul_pkg::S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with a reference product model.
// A monitor scores every output cycle against the expected byte stream.
module tb_matmul_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       load_done;
    logic       out_ready;
    logic       load_en;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic [7:0] out_data;
    logic [7:0] a_in [0:8];
    logic [7:0] b_in [0:8];

    always #5 clk = ~clk;

    matmul_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .load_en  (load_en),
        .load_done(load_done),
        .a_in     (a_in),
        .b_in     (b_in),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  ma [0:8];
    logic [7:0]  mb [0:8];
    int unsigned c_exp [0:8];
    logic [7:0]  exp_q [0:26];
    logic [7:0]  got [0:26];
    int          exp_idx;
    bit          active = 1'b0;
    bit          end_pending;
    logic        pv;
    logic        pr;
    logic [7:0]  pd;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain dot products, then split each result into 3 bytes.
    task automatic build_model();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int unsigned s;
                s = 0;
                for (int k = 0; k < 3; k++) begin
                    s += int'(ma[3*i+k]) * int'(mb[3*k+j]);
                end
                c_exp[3*i+j] = s;
            end
        end
        for (int e = 0; e < 9; e++) begin
            for (int b = 0; b < 3; b++) begin
                exp_q[3*e+b] = 8'((c_exp[e] >> (8*b)) & 255);
            end
        end
    endtask

    // kind: 0 identity, 1 values 1..9, 2 all 0xFF
    task automatic set_mats(input int ka, input int kb);
        for (int n = 0; n < 9; n++) begin
            case (ka)
                0:       ma[n] = (n % 4 == 0) ? 8'd1 : 8'd0;
                1:       ma[n] = 8'(n + 1);
                default: ma[n] = 8'hFF;
            endcase
            case (kb)
                0:       mb[n] = (n % 4 == 0) ? 8'd1 : 8'd0;
                1:       mb[n] = 8'(n + 1);
                default: mb[n] = 8'hFF;
            endcase
            a_in[n] = ma[n];
            b_in[n] = mb[n];
        end
    endtask

    // Per-cycle output scoring, sampled just after the falling edge.
    always @(negedge clk) begin
        #1;
        if (active && reset) begin
            if (end_pending) begin
                chk("done_after_last", done, 1);
                chk("valid_after_last", out_valid, 0);
                end_pending = 1'b0;
            end
            if (!out_valid) chk("data_idle_zero", out_data, 0);
            if (pv && !pr && out_valid) chk("data_stable", out_data, pd);
            if (out_valid && out_ready) begin
                if (exp_idx < 27) begin
                    chk($sformatf("byte%0d", exp_idx), out_data,
                        exp_q[exp_idx]);
                    got[exp_idx] = out_data;
                end else begin
                    chk("byte_count", exp_idx, 26);
                end
                exp_idx++;
                if (exp_idx == 27) end_pending = 1'b1;
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
        end else begin
            pv = 1'b0;
        end
    end

    // mode: 0 always ready, 1 five-cycle stall at element 4 byte 1, 2 random
    task automatic run_job(input int mode, input bit preset,
                           input int ld_delay);
        int stall;
        int cnt;
        build_model();
        exp_idx     = 0;
        end_pending = 1'b0;
        pv          = 1'b0;
        out_ready   = 1'b0;
        active      = 1'b1;
        if (preset) load_done = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("load_en_after_start", load_en, 1);
        chk("busy_after_start", busy, 1);
        if (!preset) begin
            repeat (ld_delay) begin
                @(negedge clk);
                chk("load_en_held", load_en, 1);
            end
            load_done = 1'b1;
        end
        for (int n = 1; n <= 28; n++) begin
            @(negedge clk);
            if (n == 5) start = 1'b1;
            if (n == 6) start = 1'b0;
            if (n == 1) chk("load_en_dropped", load_en, 0);
            if (n == 14) chk("busy_in_compute", busy, 1);
            if (n == 27) chk("valid_before_output", out_valid, 0);
            if (n == 28) chk("valid_at_output", out_valid, 1);
        end
        stall = 0;
        cnt   = 0;
        while (!done && cnt < 500) begin
            case (mode)
                0: out_ready = 1'b1;
                1: begin
                    if (exp_idx == 13 && stall < 5) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            cnt++;
        end
        #2;
        chk("job_done", done, 1);
        chk("job_busy_low", busy, 0);
        chk("bytes_total", exp_idx, 27);
        out_ready = 1'b0;
        active    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_load_en", load_en, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        load_done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        load_done = 1'b0;
        out_ready = 1'b0;
        for (int n = 0; n < 9; n++) begin
            a_in[n] = 8'h00;
            b_in[n] = 8'h00;
        end
        #12;
        chk("init_load_en", load_en, 0);
        chk("init_valid", out_valid, 0);
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        chk("init_data", out_data, 0);
        @(negedge clk);
        reset = 1'b1;

        set_mats(0, 1);
        run_job(0, 1'b0, 3);
        chk("id_c4", c_exp[4], 5);
        chk("id_b0", got[0], 8'h01);
        chk("id_b1", got[1], 8'h00);
        chk("id_b3", got[3], 8'h02);
        chk("id_b24", got[24], 8'h09);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("fin_start_done", done, 1);
        chk("fin_start_busy", busy, 0);
        chk("fin_start_load_en", load_en, 0);
        chk("fin_start_valid", out_valid, 0);

        do_reset();
        set_mats(2, 2);
        run_job(1, 1'b0, 1);
        chk("ff_c0", c_exp[0], 195075);
        chk("ff_b12", got[12], 8'h03);
        chk("ff_b13", got[13], 8'hFA);
        chk("ff_b14", got[14], 8'h02);

        do_reset();
        set_mats(1, 1);
        run_job(2, 1'b1, 0);
        chk("seq_c0", c_exp[0], 30);
        chk("seq_c8", c_exp[8], 150);
        chk("seq_b0", got[0], 8'h1E);
        chk("seq_b3", got[3], 8'h24);

        do_reset();
        set_mats(2, 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        load_done = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_load_en", load_en, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_data", out_data, 0);
        load_done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        set_mats(1, 0);
        run_job(0, 1'b0, 2);
        chk("rel_c7", c_exp[7], 8);
        chk("rel_b21", got[21], 8'h08);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Top-level controller for the 3x3 unsigned 8-bit matrix multiplier. It starts a job, enables the serial operand loader until both matrices are captured, and computes all nine products C = A×B on one shared multiply-accumulate unit, one MAC per cycle. It then streams the nine 18-bit results out as 27 bytes over a valid/ready handshake. It sits between the operand loader (which supplies the A/B register arrays and its sticky done flag) and the pin-level output path.

## Interface
Parameters:
- `N`, 3, matrix dimension (fixed; other values unsupported)
- `DW`, 8, operand width
- `RW`, 18, result width; must be at least 2*DW + ceil(log2 N)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low
- `start`  in  1  job request; sampled only in IDLE
- `load_en`  out  1  drives the loader's enable input
- `load_done`  in  1  loader's sticky done flag
- `a_in`  in  DW × 9 (unpacked [0:8])  matrix A, row-major
- `b_in`  in  DW × 9 (unpacked [0:8])  matrix B, row-major
- `out_data`  out  8  result byte
- `out_valid`  out  1  result byte available
- `out_ready`  in  1  downstream accepts the byte
- `busy`  out  1  high in LOAD, COMPUTE and OUTPUT
- `done`  out  1  job complete; sticky until reset

## Operation
- **States:** IDLE, LOAD, COMPUTE, OUTPUT, FINISH.
- **IDLE:**
  - `start`=1 → LOAD.
- **LOAD:**
  - `load_en`=1.
  - `load_done`=1 → COMPUTE.
- **COMPUTE:**
  - Nested counters over i (row) 0..2, j (column) 0..2 and k 0..2, with k innermost, then j, then i.
  - Each cycle forms the product `a_in[3i+k]` × `b_in[3k+j]`.
  - k=0: the accumulator loads the product (clear-and-load).
  - k=1, 2: the product is added to the accumulator.
  - k=2: the final sum is written to result register `C[3i+j]`.
  - After i=j=k=2 → OUTPUT.
- **OUTPUT:**
  - Element index e runs 0..8; byte index b runs 0..2.
  - `out_data` = `C[e]` zero-extended to 24 bits, byte b, sent LSB first.
  - On each `out_valid` && `out_ready`: b advances; after b=2, b wraps to 0 and e advances.
  - Accepting e=8, b=2 → FINISH.
- **FINISH:**
  - `done`=1, `busy`=0.
  - Stays in FINISH until reset. A new job requires a reset, because the loader must also be reset.
- **Arithmetic:** unsigned throughout, with no overflow. The maximum result is 3·255² = 195075 (0x2FA03).
- `start` is ignored in every state except IDLE.
- `load_done` is allowed to be already high on entry to LOAD; LOAD then lasts exactly one cycle.

## Timing
- **Reset values:** state=IDLE; `load_en`, `out_valid`, `busy`, `done`=0; `out_data`=0x00; counters=0; accumulator=0; `C[0:8]`=0.
- **Reset mid-operation:** the reset asserts asynchronously from any state and restores all reset values immediately. No partial output continues after it deasserts.
- **Start to LOAD:** `start` sampled high in IDLE at edge t. LOAD and `busy` are active from t+1.
- **LOAD to OUTPUT:** `load_done` sampled high in LOAD at edge u.
  - COMPUTE occupies cycles u+1 .. u+27, exactly 27 cycles.
  - OUTPUT begins at u+28, with `out_valid`=1 in that cycle.
- **Handshake:**
  - `out_valid` stays high throughout OUTPUT.
  - `out_data` is stable while `out_ready`=0.
  - A byte transfers on every clock edge where both `out_valid` and `out_ready` are high, giving at most one byte per cycle.
  - `out_data` is 0x00 whenever `out_valid`=0.
- **End of job:** after the 27th accepted byte, `out_valid`=0 and `done`=1 on the next cycle.

## Structure
- **Package `matmul_pkg`:**
  - Constants: N, DW, RW, ELEMS=9, BYTES_PER_RES=3.
  - State enum type.
- **Sub-module `mac_unit`:**
  - DW×DW multiplier feeding an RW-bit accumulator.
  - Inputs: `clear_load`, `acc_en`.
  - Output: `acc`.
- **This block:** FSM, counters, result register file and byte mux.

## Test plan
- **Identity A, B=1..9 row-major:**
  - `C` = 1..9.
  - Byte stream: 01 00 00 02 00 00 … 09 00 00.
  - `done` rises after the 27th byte.
- **A=B=all 0xFF:** every result is 195075; each element is sent as 03 FA 02.
- **A=B=1..9:**
  - `C` = 30, 36, 42, 66, 81, 96, 102, 126, 150.
  - First bytes: 1E 00 00 24 00 00.
- **Backpressure:**
  - Hold `out_ready`=0 for 5 cycles during element 4, byte 1: `out_data` stays stable and no byte is lost or duplicated.
  - Random `out_ready` gives the same 27-byte stream.
- **Reset during COMPUTE (cycle 10):**
  - All outputs are 0 and the state is IDLE.
  - A fresh `start` plus a reload yields correct results.
- **`start` and `load_done` edge cases:**
  - `start` pulsed in COMPUTE or FINISH is ignored.
  - `load_done` already high on entry to LOAD: COMPUTE follows after one LOAD cycle, and `out_valid` rises 28 cycles after the `load_done` sample.
